pulse_interval_meter: RTL

Downstream consumer of the pulse detector's single-cycle `pulse_out` stream. It measures the clk-cycle interval between consecutive detected pulses and keeps a running pulse count. Each measured interval is delivered over a one-deep valid/ready output register. It sits between the pulse detector and the register/readout logic that logs pulse timing.

---
 rtl/pulse_interval_meter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pulse_interval_meter.sv
// Measures clk-cycle intervals between consecutive pulse_in pulses and counts pulses.
// Optional idle timeout is enabled by defining PULSE_IVL_TIMEOUT_EN.
module pulse_interval_meter #(
  parameter int unsigned IVL_W   = 16,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pulse_in,
  input  logic             clr,
  output logic             iv_valid,
  input  logic             iv_ready,
  output logic [IVL_W-1:0] iv_data,
  output logic             iv_sat,
  output logic [CNT_W-1:0] pulse_count,
  output logic             overrun,
  output logic             timeout
);

`ifdef PULSE_IVL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [IVL_W-1:0] CNT_MAX = '1;
  localparam logic [IVL_W-1:0] TO_VAL  = IVL_W'(TIMEOUT);
  localparam logic [IVL_W-1:0] CNT_ONE = IVL_W'(1);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           state_q, state_d;
  logic [IVL_W-1:0] cnt_q, cnt_d;
  logic             iv_valid_q, iv_valid_d;
  logic [IVL_W-1:0] iv_data_q, iv_data_d;
  logic             iv_sat_q, iv_sat_d;
  logic [CNT_W-1:0] pulse_count_q, pulse_count_d;
  logic             overrun_q, overrun_d;
  logic             timeout_q, timeout_d;
  logic             capture;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    capture   = 1'b0;
    if (!en) begin
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      if (pulse_in) begin
        state_d = MEASURE;
        cnt_d   = CNT_ONE;
      end
    end else if (pulse_in) begin
      capture = 1'b1;
      cnt_d   = CNT_ONE;
    end else if (TO_EN && (cnt_q == TO_VAL)) begin
      state_d   = IDLE;
      timeout_d = 1'b1;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // A capture while the held result is being taken replaces it; otherwise it is dropped.
  always_comb begin
    iv_valid_d    = iv_valid_q;
    iv_data_d     = iv_data_q;
    iv_sat_d      = iv_sat_q;
    overrun_d     = clr ? 1'b0 : overrun_q;
    pulse_count_d = pulse_count_q;
    if (en && pulse_in) begin
      pulse_count_d = pulse_count_q + CNT_W'(1);
    end
    if (clr) begin
      pulse_count_d = '0;
    end
    if (capture) begin
      if (!iv_valid_q || iv_ready) begin
        iv_valid_d = 1'b1;
        iv_data_d  = cnt_q;
        iv_sat_d   = (cnt_q == CNT_MAX);
      end else begin
        overrun_d = 1'b1;
      end
    end else if (iv_valid_q && iv_ready) begin
      iv_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      iv_valid_q    <= 1'b0;
      iv_data_q     <= '0;
      iv_sat_q      <= 1'b0;
      pulse_count_q <= '0;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      iv_valid_q    <= iv_valid_d;
      iv_data_q     <= iv_data_d;
      iv_sat_q      <= iv_sat_d;
      pulse_count_q <= pulse_count_d;
      overrun_q     <= overrun_d;
      timeout_q     <= timeout_d;
    end
  end

  assign iv_valid    = iv_valid_q;
  assign iv_data     = iv_data_q;
  assign iv_sat      = iv_sat_q;
  assign pulse_count = pulse_count_q;
  assign overrun     = overrun_q;
  assign timeout     = timeout_q;

endmodule
